unbinning: RTL and testbench

// - Inverse of the 4x4 binning stage: stores the 320x180 binned 1-bit frame and replays it at 1280x720 display timing.
// - Each stored bit is replicated over a 4x4 display block. Sits between the binning output and the video/HDMI pixel mux.
// - Uses double buffering, so the display never shows a partially written frame.

---
 rtl/unbin_pkg.sv | 18 +
 rtl/unbin_bram.sv | 30 +++
 rtl/unbinning.sv | 152 +++++++++++++++
 tb/tb_unbinning.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unbin_pkg.sv
// Shared geometry, write-FSM state type and the shift-add binned address helper
// for the unbinning (1-bit 4x4 upscaler) block.
package unbin_pkg;

   localparam int BIN_W  = 320;
   localparam int BIN_H  = 180;
   localparam int DISP_W = 1280;
   localparam int DISP_H = 720;
   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {SYNC, FILL, FULL} wr_state_t;

   // v*320 + h as (v<<8) + (v<<6) + h, all terms widened to 16 bits
   function automatic logic [ADDR_W-1:0] bin_addr(input logic [7:0] v, input logic [8:0] h);
      return {v, 8'b0} + {2'b0, v, 6'b0} + {7'b0, h};
   endfunction

endpackage

// File: rtl/unbin_bram.sv
// Two-bank, 1-bit simple dual-port frame store; address MSB selects the bank,
// registered read with one cycle latency, independent write port.
module unbin_bram
   import unbin_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W:0]   i_waddr,
   input  logic              i_wdata,
   input  logic [ADDR_W:0]   i_raddr,
   output logic              o_rdata
);

   localparam int BANK_D = BIN_W * BIN_H;

   logic r_mem [0:1][0:BANK_D-1];
   logic r_q;

   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_waddr[ADDR_W]][i_waddr[ADDR_W-1:0]] <= i_wdata;
   end

   always_ff @(posedge i_clk) begin
      r_q <= r_mem[i_raddr[ADDR_W]][i_raddr[ADDR_W-1:0]];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/unbinning.sv
// Double-buffered 320x180 -> 1280x720 pixel replicator with a 2-cycle read path.
// Optional bin-border overlay enabled by defining UNBIN_GRID_OVERLAY_EN.
module unbinning
   import unbin_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        bin_valid_in,
   input  logic [8:0]  bin_hcount_in,
   input  logic [7:0]  bin_vcount_in,
   input  logic        bin_pixel_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
`ifdef UNBIN_GRID_OVERLAY_EN
   input  logic        grid_en_in,
`endif
   output logic        pixel_out,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        active_out,
   output logic        swap_out
);

   wr_state_t r_state, w_state_nxt;
   logic r_rd_bank, r_shown_valid, r_swap_out;
   logic w_wr_ok, w_first, w_last, w_swap_pt, w_we, w_swap;
   logic w_in_range;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W:0]   w_waddr;
   logic [ADDR_W:0]   r_raddr_p1;
   logic              r_in_range_p1, r_in_range_p2;
   logic [10:0]       r_hcount_p1, r_hcount_p2;
   logic [9:0]        r_vcount_p1, r_vcount_p2;
   logic              w_ram_q;

   always_comb begin
      w_wr_ok   = bin_valid_in && (bin_hcount_in < 9'(BIN_W)) && (bin_vcount_in < 8'(BIN_H));
      w_first   = (bin_hcount_in == 9'd0) && (bin_vcount_in == 8'd0);
      w_last    = (bin_hcount_in == 9'(BIN_W-1)) && (bin_vcount_in == 8'(BIN_H-1));
      w_swap_pt = (hcount_in == 11'd0) && (vcount_in == 10'(DISP_H));
   end

   // A completed frame swaps at the first vblank pixel, even if it completes on that cycle
   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_swap      = 1'b0;
      case (r_state)
         SYNC: begin
            if (w_wr_ok && w_first) begin
               w_we        = 1'b1;
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            if (w_wr_ok) begin
               w_we = 1'b1;
               if (w_last) begin
                  if (w_swap_pt) begin
                     w_swap      = 1'b1;
                     w_state_nxt = SYNC;
                  end else begin
                     w_state_nxt = FULL;
                  end
               end
            end
         end
         FULL: begin
            if (w_swap_pt) begin
               w_swap      = 1'b1;
               w_state_nxt = SYNC;
            end
         end
         default: w_state_nxt = SYNC;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= SYNC;
         r_rd_bank     <= 1'b0;
         r_shown_valid <= 1'b0;
         r_swap_out    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_swap_out <= w_swap;
         if (w_swap) begin
            r_rd_bank     <= ~r_rd_bank;
            r_shown_valid <= 1'b1;
         end
      end
   end

   assign w_waddr    = {~r_rd_bank, bin_addr(bin_vcount_in, bin_hcount_in)};
   assign w_in_range = (hcount_in < 11'(DISP_W)) && (vcount_in < 10'(DISP_H));
   assign w_rd_addr  = w_in_range ? bin_addr(vcount_in[9:2], hcount_in[10:2]) : '0;

`ifdef UNBIN_GRID_OVERLAY_EN
   logic w_grid, r_grid_p1, r_grid_p2;
   assign w_grid = grid_en_in && ((hcount_in[1:0] == 2'd0) || (vcount_in[1:0] == 2'd0));
`endif

   // Stage 1: display position -> bank-qualified read address
   // Stage 2: RAM read data alongside the delayed position
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_raddr_p1    <= '0;
         r_in_range_p1 <= 1'b0;
         r_hcount_p1   <= '0;
         r_vcount_p1   <= '0;
         r_in_range_p2 <= 1'b0;
         r_hcount_p2   <= '0;
         r_vcount_p2   <= '0;
`ifdef UNBIN_GRID_OVERLAY_EN
         r_grid_p1     <= 1'b0;
         r_grid_p2     <= 1'b0;
`endif
      end else begin
         r_raddr_p1    <= {r_rd_bank, w_rd_addr};
         r_in_range_p1 <= w_in_range;
         r_hcount_p1   <= hcount_in;
         r_vcount_p1   <= vcount_in;
         r_in_range_p2 <= r_in_range_p1;
         r_hcount_p2   <= r_hcount_p1;
         r_vcount_p2   <= r_vcount_p1;
`ifdef UNBIN_GRID_OVERLAY_EN
         r_grid_p1     <= w_grid;
         r_grid_p2     <= r_grid_p1;
`endif
      end
   end

   unbin_bram u_bram (
      .i_clk   (clk_in),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (bin_pixel_in),
      .i_raddr (r_raddr_p1),
      .o_rdata (w_ram_q)
   );

`ifdef UNBIN_GRID_OVERLAY_EN
   assign pixel_out = r_in_range_p2 & ((w_ram_q & r_shown_valid) | r_grid_p2);
`else
   assign pixel_out = w_ram_q & r_in_range_p2 & r_shown_valid;
`endif
   assign hcount_out = r_hcount_p2;
   assign vcount_out = r_vcount_p2;
   assign active_out = r_in_range_p2;
   assign swap_out   = r_swap_out;

endmodule

// File: tb/tb_unbinning.sv
// Directed bench for unbinning: blank display, frame fill/swap, FULL write drop,
// same-cycle final write and swap, mid-fill reset, optional grid overlay.
module tb_unbinning;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        bin_valid_in = 1'b0;
   logic [8:0]  bin_hcount_in = '0;
   logic [7:0]  bin_vcount_in = '0;
   logic        bin_pixel_in = 1'b0;
   logic [10:0] hcount_in = 11'd1300;
   logic [9:0]  vcount_in = '0;
   logic        pixel_out, active_out, swap_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
`ifdef UNBIN_GRID_OVERLAY_EN
   logic        grid_en_in = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   int swap_cnt = 0;

   unbinning dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .bin_valid_in  (bin_valid_in),
      .bin_hcount_in (bin_hcount_in),
      .bin_vcount_in (bin_vcount_in),
      .bin_pixel_in  (bin_pixel_in),
      .hcount_in     (hcount_in),
      .vcount_in     (vcount_in),
`ifdef UNBIN_GRID_OVERLAY_EN
      .grid_en_in    (grid_en_in),
`endif
      .pixel_out     (pixel_out),
      .hcount_out    (hcount_out),
      .vcount_out    (vcount_out),
      .active_out    (active_out),
      .swap_out      (swap_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) if (swap_out === 1'b1) swap_cnt++;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic cb(input int x, input int y);
      return logic'(((x >> 2) ^ (y >> 2)) & 1);
   endfunction

   // Entry and exit of every driver: 1 time unit after a rising edge
   task automatic wr(input int h, input int v, input logic p);
      bin_valid_in = 1'b1; bin_hcount_in = 9'(h); bin_vcount_in = 8'(v); bin_pixel_in = p;
      @(posedge clk_in); #1;
      bin_valid_in = 1'b0;
   endtask

   task automatic capture(input int x, input int y, output logic pix, output logic act,
                          output logic [10:0] hc, output logic [9:0] vc);
      hcount_in = 11'(x); vcount_in = 10'(y);
      @(posedge clk_in); @(posedge clk_in); #1;
      pix = pixel_out; act = active_out; hc = hcount_out; vc = vcount_out;
      hcount_in = 11'd1300; vcount_in = 10'd0;
   endtask

   task automatic pulse_swap(output logic s1, output logic s2);
      hcount_in = 11'd0; vcount_in = 10'd720;
      @(posedge clk_in); #1; s1 = swap_out;
      hcount_in = 11'd1300; vcount_in = 10'd0;
      @(posedge clk_in); #1; s2 = swap_out;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      bin_valid_in = 1'b1; bin_hcount_in = 9'd0; bin_vcount_in = 8'd0; bin_pixel_in = 1'b1;
      hcount_in = 11'd4; vcount_in = 10'd4;
      repeat (3) @(posedge clk_in);
      #1;
      checks++; if (pixel_out !== 1'b0) begin errors++; $display("FAIL reset_pixel: got %b want 0", pixel_out); end
      checks++; if (active_out !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active_out); end
      checks++; if (swap_out !== 1'b0) begin errors++; $display("FAIL reset_swap: got %b want 0", swap_out); end
      checks++; if (hcount_out !== 11'd0 || vcount_out !== 10'd0)
         begin errors++; $display("FAIL reset_counts: got %0d,%0d want 0,0", hcount_out, vcount_out); end
      rst_in = 1'b0; bin_valid_in = 1'b0; hcount_in = 11'd1300; vcount_in = 10'd0;
      @(posedge clk_in); #1;
   endtask

   task automatic test_no_writes();
      logic pix, act; logic [10:0] hc; logic [9:0] vc;
      int ys[3];
      int base;
      logic exp_act;
      ys = '{0, 719, 720};
      base = swap_cnt;
      foreach (ys[i]) begin
         for (int x = 0; x < 1650; x++) begin
            capture(x, ys[i], pix, act, hc, vc);
            exp_act = (x < 1280 && ys[i] < 720);
            checks++; if (pix !== 1'b0) begin errors++; $display("FAIL blank_pixel (%0d,%0d): got %b want 0", x, ys[i], pix); end
            checks++; if (act !== exp_act) begin errors++; $display("FAIL blank_active (%0d,%0d): got %b want %b", x, ys[i], act, exp_act); end
            checks++; if (hc !== 11'(x) || vc !== 10'(ys[i]))
               begin errors++; $display("FAIL blank_counts: got %0d,%0d want %0d,%0d", hc, vc, x, ys[i]); end
         end
      end
      checks++; if (swap_cnt != base) begin errors++; $display("FAIL blank_swaps: got %0d want 0", swap_cnt - base); end
   endtask

   task automatic test_sync_ignore();
      logic s1, s2, pix, act; logic [10:0] hc; logic [9:0] vc;
      wr(319, 179, 1'b1);
      wr(5, 0, 1'b1);
      pulse_swap(s1, s2);
      checks++; if (s1 !== 1'b0 || s2 !== 1'b0) begin errors++; $display("FAIL sync_ignore_swap: got %b%b want 00", s1, s2); end
      capture(4, 0, pix, act, hc, vc);
      checks++; if (pix !== 1'b0) begin errors++; $display("FAIL sync_ignore_pixel: got %b want 0", pix); end
   endtask

   task automatic test_checkerboard();
      logic s1, s2, pix, act; logic [10:0] hc; logic [9:0] vc;
      int ys[3];
      logic exp_pix;
      for (int v = 0; v < 180; v++)
         for (int h = 0; h < 320; h++)
            wr(h, v, logic'((h ^ v) & 1));
      capture(4, 0, pix, act, hc, vc);
      checks++; if (pix !== 1'b0) begin errors++; $display("FAIL cb_before_swap: got %b want 0", pix); end
      pulse_swap(s1, s2);
      checks++; if (s1 !== 1'b1 || s2 !== 1'b0) begin errors++; $display("FAIL cb_swap: got %b%b want 10", s1, s2); end
      ys = '{0, 5, 719};
      foreach (ys[i]) begin
         for (int x = 0; x < 1284; x++) begin
            capture(x, ys[i], pix, act, hc, vc);
            exp_pix = (x < 1280) ? cb(x, ys[i]) : 1'b0;
            checks++; if (pix !== exp_pix) begin errors++; $display("FAIL cb_pixel (%0d,%0d): got %b want %b", x, ys[i], pix, exp_pix); end
            checks++; if (act !== logic'(x < 1280)) begin errors++; $display("FAIL cb_active (%0d,%0d): got %b", x, ys[i], act); end
         end
      end
   endtask

   task automatic test_full_drop();
      logic s1, s2, pix, act; logic [10:0] hc; logic [9:0] vc;
      for (int h = 0; h < 8; h++) wr(h, 0, 1'b0);
      wr(319, 179, 1'b0);
      for (int h = 0; h < 8; h++) wr(h, 0, 1'b1);
      wr(319, 179, 1'b1);
      capture(4, 0, pix, act, hc, vc);
      checks++; if (pix !== 1'b1) begin errors++; $display("FAIL full_old_frame: got %b want 1", pix); end
      pulse_swap(s1, s2);
      checks++; if (s1 !== 1'b1 || s2 !== 1'b0) begin errors++; $display("FAIL full_swap: got %b%b want 10", s1, s2); end
      for (int x = 0; x < 32; x++) begin
         capture(x, 2, pix, act, hc, vc);
         checks++; if (pix !== 1'b0) begin errors++; $display("FAIL full_drop_pixel (%0d,2): got %b want 0", x, pix); end
      end
      capture(1279, 719, pix, act, hc, vc);
      checks++; if (pix !== 1'b0) begin errors++; $display("FAIL full_drop_last: got %b want 0", pix); end
   endtask

   task automatic test_same_cycle();
      logic s1, s2, pix, act; logic [10:0] hc; logic [9:0] vc;
      int xs[8], ys[8];
      logic ex[8];
      wr(0, 0, 1'b1);
      wr(1, 0, 1'b0);
      wr(321, 0, 1'b1);
      wr(0, 180, 1'b1);
      bin_valid_in = 1'b1; bin_hcount_in = 9'd319; bin_vcount_in = 8'd179; bin_pixel_in = 1'b1;
      hcount_in = 11'd0; vcount_in = 10'd720;
      @(posedge clk_in); #1;
      s1 = swap_out;
      bin_valid_in = 1'b0; hcount_in = 11'd1300; vcount_in = 10'd0;
      @(posedge clk_in); #1;
      s2 = swap_out;
      checks++; if (s1 !== 1'b1 || s2 !== 1'b0) begin errors++; $display("FAIL same_cycle_swap: got %b%b want 10", s1, s2); end
      xs = '{1279, 1276, 0, 4, 8, 12, 4, 0};
      ys = '{719,  716,  0, 0, 0, 0,  4, 4};
      ex = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      foreach (xs[i]) begin
         capture(xs[i], ys[i], pix, act, hc, vc);
         checks++; if (pix !== ex[i]) begin errors++; $display("FAIL same_cycle_pixel (%0d,%0d): got %b want %b", xs[i], ys[i], pix, ex[i]); end
      end
   endtask

   task automatic test_reset_mid_fill();
      logic s1, s2, pix, act; logic [10:0] hc; logic [9:0] vc;
      int xs[6];
      logic ex[6];
      wr(0, 0, 1'b1);
      wr(1, 0, 1'b1);
      hcount_in = 11'd4; vcount_in = 10'd4;
      repeat (2) @(posedge clk_in);
      #1;
      checks++; if (active_out !== 1'b1 || hcount_out !== 11'd4) begin errors++; $display("FAIL pre_reset_active: got %b,%0d want 1,4", active_out, hcount_out); end
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      checks++; if (pixel_out !== 1'b0 || active_out !== 1'b0 || swap_out !== 1'b0)
         begin errors++; $display("FAIL mid_reset_outputs: got %b%b%b want 000", pixel_out, active_out, swap_out); end
      checks++; if (hcount_out !== 11'd0 || vcount_out !== 10'd0)
         begin errors++; $display("FAIL mid_reset_counts: got %0d,%0d want 0,0", hcount_out, vcount_out); end
      rst_in = 1'b0; hcount_in = 11'd1300; vcount_in = 10'd0;
      wr(2, 0, 1'b1);
      wr(319, 179, 1'b1);
      pulse_swap(s1, s2);
      checks++; if (s1 !== 1'b0 || s2 !== 1'b0) begin errors++; $display("FAIL post_reset_noswap: got %b%b want 00", s1, s2); end
      capture(4, 0, pix, act, hc, vc);
      checks++; if (pix !== 1'b0) begin errors++; $display("FAIL post_reset_pixel: got %b want 0", pix); end
      wr(0, 0, 1'b0);
      wr(1, 0, 1'b1);
      wr(319, 179, 1'b1);
      pulse_swap(s1, s2);
      checks++; if (s1 !== 1'b1 || s2 !== 1'b0) begin errors++; $display("FAIL rewrite_swap: got %b%b want 10", s1, s2); end
      xs = '{0, 4, 8, 12, 1279, 4};
      ex = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      foreach (xs[i]) begin
         capture(xs[i], (i == 4) ? 719 : ((i == 5) ? 4 : 0), pix, act, hc, vc);
         checks++; if (pix !== ex[i]) begin errors++; $display("FAIL rewrite_pixel #%0d x=%0d: got %b want %b", i, xs[i], pix, ex[i]); end
      end
   endtask

`ifdef UNBIN_GRID_OVERLAY_EN
   task automatic test_grid();
      logic pix, act; logic [10:0] hc; logic [9:0] vc;
      int xs[5], ys[5];
      logic ex[5];
      capture(0, 0, pix, act, hc, vc);
      checks++; if (pix !== 1'b0) begin errors++; $display("FAIL grid_off: got %b want 0", pix); end
      grid_en_in = 1'b1;
      xs = '{0, 0, 5, 5, 1280};
      ys = '{0, 5, 8, 5, 0};
      ex = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      foreach (xs[i]) begin
         capture(xs[i], ys[i], pix, act, hc, vc);
         checks++; if (pix !== ex[i]) begin errors++; $display("FAIL grid_pixel (%0d,%0d): got %b want %b", xs[i], ys[i], pix, ex[i]); end
      end
      grid_en_in = 1'b0;
   endtask
`endif

   initial begin
      @(posedge clk_in); #1;
      test_reset();
      test_no_writes();
      test_sync_ignore();
      test_checkerboard();
      test_full_drop();
      test_same_cycle();
      test_reset_mid_fill();
`ifdef UNBIN_GRID_OVERLAY_EN
      test_grid();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
